// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one combinational 4-bit ALU between NREQ requesters.
// ALU drive and response are registered; only req_ready is combinational (IDLE only).
//
// state | meaning
// IDLE  | arbitrate; req_ready high for the chosen requester, latch its op on the edge
// ISSUE | ALU inputs held, counting down ALU_LAT-1 extra cycles
// WAIT  | capture alu_result and owner into the response registers
// RESP  | response held stable until rsp_ready
module alu_rr_sched #(
  parameter int NREQ    = 4,
  parameter int ALU_LAT = 1,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*4-1:0]   req_a,
  input  logic [NREQ*4-1:0]   req_b,
  input  logic [NREQ*2-1:0]   req_op,
  output logic [3:0]          alu_a,
  output logic [3:0]          alu_b,
  output logic [1:0]          alu_op,
  input  logic [4:0]          alu_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [4:0]          rsp_result,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_found;
  logic [2:0]     lat_cnt;
  logic [3:0]     sel_a;
  logic [3:0]     sel_b;
  logic [1:0]     sel_op;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // First valid requester at or after rr_ptr, wrapping past NREQ-1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && req_valid[wrap_add(rr_ptr, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_add(rr_ptr, k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign sel_a  = req_a[4*gnt_idx +: 4];
  assign sel_b  = req_b[4*gnt_idx +: 4];
  assign sel_op = req_op[2*gnt_idx +: 2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      lat_cnt    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            alu_a   <= sel_a;
            alu_b   <= sel_b;
            alu_op  <= sel_op;
            owner   <= gnt_idx;
            rr_ptr  <= wrap_add(gnt_idx, 1);
            lat_cnt <= 3'(ALU_LAT - 1);
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (lat_cnt == 3'd0) state <= WAIT;
          else lat_cnt <= lat_cnt - 3'd1;
        end
        WAIT: begin
          rsp_result <= alu_result;
          rsp_id     <= owner;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          // ALU inputs deliberately keep the last op here and in IDLE.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Scoreboard bench for alu_rr_sched: round-robin model predicts req_ready each cycle,
// expected responses are queued at grant and compared on the response handshake.
module tb_alu_rr_sched;

  localparam int NREQ = 4;

  typedef struct {
    logic [1:0] id;
    logic [4:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*4-1:0] req_a;
  logic [NREQ*4-1:0] req_b;
  logic [NREQ*2-1:0] req_op;
  logic [3:0]        alu_a;
  logic [3:0]        alu_b;
  logic [1:0]        alu_op;
  logic [4:0]        alu_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [4:0]        rsp_result;
  logic              busy;

  logic [NREQ-1:0]   req_valid3;
  logic [NREQ-1:0]   req_ready3;
  logic [NREQ*4-1:0] req_a3;
  logic [NREQ*4-1:0] req_b3;
  logic [NREQ*2-1:0] req_op3;
  logic [3:0]        alu_a3;
  logic [3:0]        alu_b3;
  logic [1:0]        alu_op3;
  logic [4:0]        alu_result3;
  logic              rsp_valid3;
  logic [1:0]        rsp_id3;
  logic [4:0]        rsp_result3;
  logic              busy3;

  function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] op);
    return (op == 2'd0) ? ({1'b0, a} + {1'b0, b}) : {1'b0, a ^ b};
  endfunction

  assign alu_result  = alu_model(alu_a, alu_b, alu_op);
  assign alu_result3 = alu_model(alu_a3, alu_b3, alu_op3);

  alu_rr_sched #(.NREQ(NREQ), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .busy(busy)
  );

  alu_rr_sched #(.NREQ(NREQ), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .req_op(req_op3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_result(alu_result3),
    .rsp_valid(rsp_valid3), .rsp_ready(1'b1), .rsp_id(rsp_id3),
    .rsp_result(rsp_result3), .busy(busy3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  exp_t            sb[$];
  int              gnt_log[$];
  int              mdl_rr;
  int              pend[NREQ];
  logic [NREQ-1:0] s_gnt;
  logic            s_rsp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pend_total();
    int t = 0;
    for (int i = 0; i < NREQ; i++) t += pend[i];
    return t;
  endfunction

  // Called on the falling edge: predict the grant, score responses.
  task automatic monitor();
    logic [NREQ-1:0] exp_rdy;
    exp_t            e;
    int              g;
    int              j;
    s_gnt = req_ready & req_valid;
    s_rsp = rsp_valid;
    if (rst) return;
    exp_rdy = '0;
    g = -1;
    if (!busy) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (mdl_rr + k) % NREQ;
        if (g < 0 && req_valid[j]) g = j;
      end
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        e.id  = 2'(g);
        e.res = alu_model(req_a[g*4 +: 4], req_b[g*4 +: 4], req_op[g*2 +: 2]);
        sb.push_back(e);
        gnt_log.push_back(g);
        mdl_rr = (g + 1) % NREQ;
      end
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
    end else begin
      check("ready_busy", 32'(req_ready), 32'd0);
    end
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_result", 32'(rsp_result), 32'(e.res));
      end
    end
  endtask

  task automatic load_op(input int i, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op);
    req_a[i*4 +: 4]  = a;
    req_b[i*4 +: 4]  = b;
    req_op[i*2 +: 2] = op;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (s_gnt[i]) begin
        pend[i]--;
        if (pend[i] > 0) load_op(i, 4'($urandom), 4'($urandom), 2'($urandom));
        else req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic post(input int i, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] op, input int n);
    pend[i] = n;
    load_op(i, a, b, op);
    req_valid[i] = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_done(input string tag);
    int n = 0;
    int left;
    do begin
      step();
      n++;
      left = pend_total() + sb.size() + int'(busy);
    end while (n < 300 && left != 0);
    if (n >= 300) check(tag, 32'(left), 32'd0);
  endtask

  task automatic wait_gnt(input int i, input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (n < 20 && !s_gnt[i]);
    if (!s_gnt[i]) check(tag, 32'(s_gnt), 32'(1 << i));
  endtask

  initial begin
    int n;
    int exp_ord[5];
    exp_t hold;
    exp_ord = '{0, 1, 2, 3, 0};
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
    req_valid3 = '0; req_a3 = '0; req_b3 = '0; req_op3 = '0;
    mdl_rr = 0; s_gnt = '0; s_rsp = 1'b0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;

    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
    check("rst_rsp", 32'({rsp_id, rsp_result}), 32'd0);
    rst = 1'b0;

    // Contention from reset: all four requesting.
    post(0, 4'h1, 4'h2, 2'd0, 2);
    post(1, 4'h3, 4'h4, 2'd1, 1);
    post(2, 4'h7, 4'h9, 2'd0, 1);
    post(3, 4'hC, 4'h5, 2'd3, 1);
    run_done("t2_timeout");
    check("t2_count", 32'(gnt_log.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < gnt_log.size()) check("t2_order", 32'(gnt_log[i]), 32'(exp_ord[i]));

    // Single op latency: rsp_valid seen on the third falling edge after the grant.
    post(0, 4'h9, 4'h8, 2'd0, 1);
    wait_gnt(0, "t1_grant");
    n = 0;
    do begin
      step();
      n++;
    end while (n < 10 && !s_rsp);
    check("t1_latency", 32'(n), 32'd3);
    check("t1_id", 32'(rsp_id), 32'd0);
    check("t1_result", 32'(rsp_result), 32'h11);
    run_done("t1_timeout");

    // Backpressure with other requesters waiting.
    rsp_ready = 1'b0;
    post(1, 4'h3, 4'h6, 2'd1, 1);
    post(2, 4'hA, 4'h4, 2'd0, 1);
    post(3, 4'h2, 4'h2, 2'd2, 1);
    n = 0;
    do begin
      step();
      n++;
    end while (n < 20 && !s_rsp);
    check("t3_rsp_seen", 32'(s_rsp), 32'd1);
    hold = sb[0];
    for (int c = 0; c < 10; c++) begin
      step();
      check("t3_hold_valid", 32'(rsp_valid), 32'd1);
      check("t3_hold_id", 32'(rsp_id), 32'(hold.id));
      check("t3_hold_result", 32'(rsp_result), 32'(hold.res));
      check("t3_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    step();
    step();
    check("t3_release", 32'(s_rsp), 32'd0);
    run_done("t3_timeout");

    // Wrap/skip: park rr at 3, then only req1 and req2 valid.
    post(2, 4'h5, 4'h5, 2'd0, 1);
    run_done("t4a_timeout");
    gnt_log.delete();
    post(1, 4'h8, 4'h8, 2'd0, 1);
    post(2, 4'hF, 4'h0, 2'd1, 1);
    run_done("t4b_timeout");
    for (int i = 0; i < NREQ; i++) post(i, 4'(i), 4'(i + 5), 2'(i), 1);
    run_done("t4c_timeout");
    check("t4_count", 32'(gnt_log.size()), 32'd6);
    if (gnt_log.size() >= 3) begin
      check("t4_first", 32'(gnt_log[0]), 32'd1);
      check("t4_second", 32'(gnt_log[1]), 32'd2);
      check("t4_after", 32'(gnt_log[2]), 32'd3);
    end

    // Reset while in WAIT, with rr pointing at 2.
    post(1, 4'hA, 4'h5, 2'd1, 1);
    wait_gnt(1, "t5_grant");
    step();
    #2;
    rst = 1'b1;
    #1;
    check("t5_ready", 32'(req_ready), 32'd0);
    check("t5_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
    check("t5_rsp", 32'({rsp_valid, rsp_id, rsp_result}), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    sb.delete();
    mdl_rr = 0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      check("t5_no_rsp", 32'(s_rsp), 32'd0);
    end
    gnt_log.delete();
    for (int i = 0; i < NREQ; i++) post(i, 4'(i + 2), 4'(i), 2'd0, 1);
    run_done("t5_timeout");
    if (gnt_log.size() > 0) check("t5_first_gnt", 32'(gnt_log[0]), 32'd0);
    else check("t5_first_gnt", 32'(gnt_log.size()), 32'd1);

    // ALU_LAT=3 instance: rsp_valid seen on the fifth falling edge after grant.
    @(posedge clk);
    #1;
    req_valid3[2] = 1'b1;
    req_a3[8 +: 4] = 4'hF;
    req_b3[8 +: 4] = 4'h1;
    req_op3[4 +: 2] = 2'd0;
    @(negedge clk);
    check("t6_ready", 32'(req_ready3), 32'h4);
    @(posedge clk);
    #1;
    req_valid3 = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 20 && !rsp_valid3);
    check("t6_latency", 32'(n), 32'd5);
    check("t6_id", 32'(rsp_id3), 32'd2);
    check("t6_result", 32'(rsp_result3), 32'h10);
    @(negedge clk);
    @(negedge clk);
    check("t6_idle", 32'({busy3, rsp_valid3}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
